// File: rtl/and_chain_pkg.sv
// Shared types and constants for the serial AND-chain sequencer.
// Holds the FSM state encoding, the legal range of N and the index-width helper.
package and_chain_pkg;

    // Legal range of the number of AND inputs
    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;

    // Default chain length and its stage-index width
    localparam int unsigned N_DEFAULT     = 4;
    localparam int unsigned IDX_W_DEFAULT = $clog2(N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the stage index for an n-input chain
    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/and_chain_seq_if.sv
// Request/response bundle between a requester and the AND-chain sequencer.
//   start   : request, taken only when the sequencer is idle
//   din     : N operands, captured with the accepted request
//   busy    : stages are being evaluated
//   done    : one-cycle pulse, result and partial are valid
//   partial : running products, partial[k] = din[0] & ... & din[k+1]
//   result  : AND of all captured operands
interface and_chain_seq_if
    import and_chain_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic         start;
    logic [N-1:0] din;
    logic         busy;
    logic         done;
    logic [N-2:0] partial;
    logic         result;

    modport master (
        output start, din,
        input  busy, done, partial, result
    );

    modport slave (
        input  start, din,
        output busy, done, partial, result
    );
endinterface

// File: rtl/and2_stage.sv
// The single shared 2-input AND resource used by every stage of the chain.
//   a, b : operands (running product and the next captured operand)
//   y    : a & b, combinational
module and2_stage (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/and_chain_seq.sv
// Serial N-input AND chain: one stage per clock through a shared AND gate,
// exposing every partial product under a start/busy/done handshake.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of and_chain_seq_if (start, din in; busy, done, partial, result out)
// Parameters: N (2..16) inputs; EARLY_EXIT stops on the first zero product.
module and_chain_seq
    import and_chain_pkg::*;
#(
    parameter int unsigned N          = N_DEFAULT,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    and_chain_seq_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(N);
    localparam int unsigned PW    = N - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (N < N_MIN || N > N_MAX) begin : g_n_range_err
        $error("and_chain_seq: N must lie in 2..16");
    end

    state_t           state;
    logic [N-1:0]     op;
    logic             acc;
    logic [IDX_W-1:0] idx;
    logic             s;

    // Shared stage: running product AND the operand selected by idx
    and2_stage u_and2 (
        .a (acc),
        .b (op[idx]),
        .y (s)
    );

    // Sequencer FSM with operand, accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= '0;
            acc         <= 1'b0;
            idx         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.partial <= '0;
            bus.result  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op          <= bus.din;
                        acc         <= bus.din[0];
                        idx         <= IDX_W'(1);
                        bus.partial <= '0;
                        bus.result  <= 1'b0;
                        bus.busy    <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    acc <= s;
                    // Each partial bit is written exactly once per run, so OR-in is enough
                    bus.partial <= bus.partial | (PW'(s) << (idx - IDX_W'(1)));
                    if (idx == LAST_IDX || (EARLY_EXIT && !s)) begin
                        bus.result <= s;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_and_chain_seq.sv
// Self-checking bench for and_chain_seq: three instances (N=4 plain, N=4 early
// exit, N=2) checked cycle by cycle against a prefix-AND reference model.
module tb_and_chain_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    and_chain_seq_if #(.N(4)) bus_a ();
    and_chain_seq_if #(.N(4)) bus_b ();
    and_chain_seq_if #(.N(2)) bus_c ();

    and_chain_seq #(.N(4), .EARLY_EXIT(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    and_chain_seq #(.N(4), .EARLY_EXIT(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    and_chain_seq #(.N(2), .EARLY_EXIT(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    int vectors    = 0;
    int miscompares = 0;

    int n_of [3] = '{4, 4, 2};
    bit ee_of[3] = '{1'b0, 1'b1, 1'b0};

    logic       busy_o[3];
    logic       done_o[3];
    logic       res_o [3];
    logic [2:0] part_o[3];

    // Reference: partial[k] is 1 iff operand bits 0..k+1 are all ones
    function automatic logic [2:0] ref_partial(input int d, input int n);
        logic [2:0] p;
        int m;
        p = '0;
        for (int k = 0; k < n - 1; k++) begin
            m = (1 << (k + 2)) - 1;
            if ((d & m) == m) p = p | (3'd1 << k);
        end
        return p;
    endfunction

    function automatic logic ref_result(input int d, input int n);
        int m;
        m = (1 << n) - 1;
        return ((d & m) == m);
    endfunction

    // Cycle (after the start edge) in which done is expected
    function automatic int ref_done_cycle(input int d, input int n, input bit ee);
        int m;
        if (ee) begin
            for (int j = 1; j < n; j++) begin
                m = (1 << (j + 1)) - 1;
                if ((d & m) != m) return j + 1;
            end
        end
        return n;
    endfunction

    task automatic sample_all();
        busy_o[0] = bus_a.busy;  done_o[0] = bus_a.done;  res_o[0] = bus_a.result;  part_o[0] = bus_a.partial;
        busy_o[1] = bus_b.busy;  done_o[1] = bus_b.done;  res_o[1] = bus_b.result;  part_o[1] = bus_b.partial;
        busy_o[2] = bus_c.busy;  done_o[2] = bus_c.done;  res_o[2] = bus_c.result;  part_o[2] = {2'b00, bus_c.partial};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
        bus_a.din = 4'($urandom); bus_b.din = 4'($urandom); bus_c.din = 2'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_all();
        for (int d = 0; d < 3; d++) begin
            vectors += 4;
            if (busy_o[d] !== 1'b0) begin miscompares++; $display("FAIL reset busy dut%0d got %b exp 0", d, busy_o[d]); end
            if (done_o[d] !== 1'b0) begin miscompares++; $display("FAIL reset done dut%0d got %b exp 0", d, done_o[d]); end
            if (part_o[d] !== 3'b000) begin miscompares++; $display("FAIL reset partial dut%0d got %b exp 000", d, part_o[d]); end
            if (res_o[d] !== 1'b0) begin miscompares++; $display("FAIL reset result dut%0d got %b exp 0", d, res_o[d]); end
        end
        rst = 1'b0;
    endtask

    // One operation on all three instances; optionally scramble din during RUN
    task automatic test_ops(input logic [3:0] da, input logic [3:0] db, input logic [1:0] dc, input bit scramble);
        int dv[3];
        int dcyc[3];
        logic [2:0] ep[3];
        logic er[3];
        logic eb, ed;
        dv[0] = int'(da); dv[1] = int'(db); dv[2] = int'(dc);
        for (int d = 0; d < 3; d++) begin
            ep[d]   = ref_partial(dv[d], n_of[d]);
            er[d]   = ref_result(dv[d], n_of[d]);
            dcyc[d] = ref_done_cycle(dv[d], n_of[d], ee_of[d]);
        end
        @(negedge clk);
        bus_a.start = 1'b1; bus_b.start = 1'b1; bus_c.start = 1'b1;
        bus_a.din = da; bus_b.din = db; bus_c.din = dc;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
        if (scramble) begin
            bus_a.din = ~da; bus_b.din = ~db; bus_c.din = ~dc;
        end
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            sample_all();
            for (int d = 0; d < 3; d++) begin
                eb = (c < dcyc[d]);
                ed = (c == dcyc[d]);
                vectors += 2;
                if (busy_o[d] !== eb) begin
                    miscompares++;
                    $display("FAIL ops busy dut%0d din=%h cyc=%0d got %b exp %b", d, dv[d], c, busy_o[d], eb);
                end
                if (done_o[d] !== ed) begin
                    miscompares++;
                    $display("FAIL ops done dut%0d din=%h cyc=%0d got %b exp %b", d, dv[d], c, done_o[d], ed);
                end
                if (c >= dcyc[d]) begin
                    vectors += 2;
                    if (part_o[d] !== ep[d]) begin
                        miscompares++;
                        $display("FAIL ops partial dut%0d din=%h cyc=%0d got %b exp %b", d, dv[d], c, part_o[d], ep[d]);
                    end
                    if (res_o[d] !== er[d]) begin
                        miscompares++;
                        $display("FAIL ops result dut%0d din=%h cyc=%0d got %b exp %b", d, dv[d], c, res_o[d], er[d]);
                    end
                end
            end
        end
    endtask

    // start re-pulsed while RUN and while DONE must not restart the chain
    task automatic test_start_ignored();
        logic eb, ed;
        @(negedge clk);
        bus_a.din = 4'b1111; bus_a.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            eb = (c >= 1 && c <= 3);
            ed = (c == 4);
            vectors += 2;
            if (bus_a.busy !== eb) begin miscompares++; $display("FAIL ignore busy cyc=%0d got %b exp %b", c, bus_a.busy, eb); end
            if (bus_a.done !== ed) begin miscompares++; $display("FAIL ignore done cyc=%0d got %b exp %b", c, bus_a.done, ed); end
            bus_a.start = (c == 2 || c == 4);
        end
        bus_a.start = 1'b0;
        vectors++;
        if (bus_a.result !== 1'b1) begin miscompares++; $display("FAIL ignore result got %b exp 1", bus_a.result); end
    endtask

    // start held high: a new operation every N+1 cycles
    task automatic test_back_to_back();
        logic eb, ed;
        int ph;
        @(negedge clk);
        bus_a.din = 4'b1111; bus_a.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            ph = c % 5;
            eb = (ph >= 1 && ph <= 3);
            ed = (ph == 4);
            vectors += 2;
            if (bus_a.busy !== eb) begin miscompares++; $display("FAIL b2b busy cyc=%0d got %b exp %b", c, bus_a.busy, eb); end
            if (bus_a.done !== ed) begin miscompares++; $display("FAIL b2b done cyc=%0d got %b exp %b", c, bus_a.done, ed); end
        end
        bus_a.start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reset in the middle of RUN aborts with no done pulse
    task automatic test_reset_mid_run();
        @(negedge clk);
        bus_a.din = 4'b1111; bus_a.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        vectors++;
        if (bus_a.busy !== 1'b1) begin miscompares++; $display("FAIL midrst busy_c1 got %b exp 1", bus_a.busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors += 4;
        if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy got %b exp 0", bus_a.busy); end
        if (bus_a.done !== 1'b0) begin miscompares++; $display("FAIL midrst done got %b exp 0", bus_a.done); end
        if (bus_a.partial !== 3'b000) begin miscompares++; $display("FAIL midrst partial got %b exp 000", bus_a.partial); end
        if (bus_a.result !== 1'b0) begin miscompares++; $display("FAIL midrst result got %b exp 0", bus_a.result); end
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            vectors += 2;
            if (bus_a.done !== 1'b0) begin miscompares++; $display("FAIL midrst late_done cyc=%0d got %b exp 0", c, bus_a.done); end
            if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL midrst late_busy cyc=%0d got %b exp 0", c, bus_a.busy); end
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
        bus_a.din = '0; bus_b.din = '0; bus_c.din = '0;
        rst = 1'b1;
        test_reset();
        test_ops(4'b1111, 4'b1111, 2'b11, 1'b0);
        test_ops(4'b1011, 4'b1101, 2'b01, 1'b1);
        test_ops(4'b1101, 4'b1110, 2'b10, 1'b1);
        test_ops(4'b0111, 4'b0111, 2'b11, 1'b0);
        for (int i = 0; i < 24; i++) begin
            test_ops(4'($urandom | $urandom), 4'($urandom | $urandom), 2'($urandom | $urandom), 1'(i % 2));
        end
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_ops(4'b1111, 4'b0011, 2'b11, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/and_chain_seq.md
Name: and_chain_seq

Overview:
- Sequencer that evaluates an N-input AND chain serially, one stage per clock, through a single shared 2-input AND stage.
- Exposes every intermediate partial product (the E/F-style taps) plus the final result, under a start/busy/done handshake.
- Sits between a requester (switch/button logic or test FSM) and the LED/seven-segment display logic in the circuit-practice designs.

Parameters:
- N, 4, number of AND inputs; legal range 2..16.
- EARLY_EXIT, 0, 1 = stop as soon as the running product is 0; 0 = always run all N-1 stages.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- din  input  N  operands; captured on the accepted start, so later changes are ignored.
- busy  output  1  high while stages are being evaluated (RUN).
- done  output  1  one-cycle pulse when the result is valid.
- partial  output  N-1  partial[k] = din[0] & ... & din[k+1]; partial[N-2] equals the result.
- result  output  1  final AND of all captured operands.

Behaviour:
- Clock/reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, partial=0, result=0, internal operand/acc/idx = 0.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs are 0 on the next cycle.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - When start=1 at an edge: op<=din, acc<=din[0], idx<=1, partial<=0, result<=0, then go to RUN.
  - When start=0: stay in IDLE.
- RUN, each cycle:
  - s = acc & op[idx], computed by the shared stage.
  - partial[idx-1]<=s and acc<=s.
  - If idx==N-1: result<=s, go to DONE.
  - Else if EARLY_EXIT and s==0: result<=0, go to DONE. Remaining partial bits stay 0, which is already correct.
  - Else idx<=idx+1.
- DONE: done=1 for exactly one cycle, then return to IDLE. start is ignored in DONE.
- busy equals (state==RUN). start is ignored while busy=1; no queueing.
- Latency, with start sampled at edge 0:
  - Without early exit: RUN covers cycles 1..N-1, done is high in cycle N, IDLE in cycle N+1.
  - Minimum start-to-start spacing is N+1 cycles.
  - With early exit at stage j (1-based), done is high in cycle j+1.
- result and partial hold their values after done until the next accepted start clears them.
- idx width is $clog2(N). Indexing never exceeds N-1.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package and_chain_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam for idx width;
  - the N range-check constants.
- One sub-module, and2_stage: the single shared 2-input AND resource (inputs a, b; output y), combinational. It is instantiated once and driven by acc and op[idx].
- The FSM, operand register and partial register live in and_chain_seq.

Test Plan:
- N=4, EARLY_EXIT=0, din=4'b1111, start pulse at edge 0 -> busy high in cycles 1-3; done high only in cycle 4; partial=3'b111, result=1; outputs held until the next start.
- N=4, din=4'b1011 (din[2]=0) -> partial=3'b001, result=0, done in cycle 4; din changed to 4'b1111 during RUN -> result unaffected.
- N=4, EARLY_EXIT=1, din=4'b1101 (din[1]=0) -> partial=3'b000, result=0, done in cycle 2, busy high in cycle 1 only. Same stimulus with EARLY_EXIT=0 -> done in cycle 4.
- start re-pulsed in cycles 2 and 4 of an operation -> ignored: single done pulse, no restart; start held continuously high -> done pulses every 5 cycles.
- rst asserted in cycle 2 of RUN -> cycle 3 shows state IDLE, busy=0, done=0, partial=0, result=0; no done pulse for the aborted operation; a fresh start afterwards completes normally.
- N=2, din=2'b11 -> done in cycle 2, partial=1'b1, result=1.
